dm_responder: RTL and testbench

- Data-memory responder for the matrix-multiplication processor.
- Services the processor's data-memory read and write requests: dm_en (request), ar_out (address), bus_out (write data), dm_out (read data), status (response).
- Holds the on-chip data RAM and inserts a configurable number of wait states.
- Reports progress and errors on a 2-bit status code consumed by the processor's control unit.

---
 rtl/dm_responder_if.sv | 28 ++
 rtl/dm_responder.sv | 170 +++++++++++++++++
 tb/tb_dm_responder.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/dm_responder_if.sv
// Processor-side data-memory port of the matrix-multiplication processor:
// request/handshake, write data, preload strobe, read data and status.
interface dm_responder_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16
);
  logic              dm_en;
  logic              dm_we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] dm_out;
  logic [1:0]        status;

  // Processor / bench side: issues requests and preloads, observes results.
  modport master (
    output dm_en, dm_we, addr, wdata, load_en, load_addr, load_data,
    input  dm_out, status
  );

  // Responder side: owns the RAM and drives read data and status.
  modport slave (
    input  dm_en, dm_we, addr, wdata, load_en, load_addr, load_data,
    output dm_out, status
  );
endinterface

// File: rtl/dm_responder.sv
// Data-memory responder: on-chip RAM with a configurable number of wait
// states and a 4-phase dm_en / status handshake toward the control unit.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for dm_en; preload strobe honoured here only
// BUSY  | request latched, counting wait states, access on last cycle
// DONE  | access complete, status=10 held until dm_en drops
// ERR   | address out of range, status=11 held until dm_en drops
module dm_responder #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 16,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input logic          clock,
  input logic          rst,
  dm_responder_if.slave bus
);

  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so a DEPTH equal to 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0]      WAIT_L  = 4'(WAIT_CYCLES);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_BUSY = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;
  localparam logic [1:0] ST_ERR  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [1:0]        status_d;
  logic [1:0]        status_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              req_we_q;
  logic [IDX_W-1:0]  req_idx_q;
  logic [DATA_W-1:0] req_wdata_q;
  logic [3:0]        count_q;
  logic [DATA_W-1:0] dout_q;

  logic              req_in_range;
  logic              load_in_range;
  logic              capture;
  logic              access_last;
  logic              do_write;
  logic              do_read;
  logic              do_load;

  assign req_in_range  = ({1'b0, bus.addr} < DEPTH_X);
  assign load_in_range = ({1'b0, bus.load_addr} < DEPTH_X);

  // Accesses fire only on the final BUSY edge; a preload needs a quiet IDLE
  // (dm_en wins) and is blocked while reset is held.
  assign do_write = access_last && req_we_q;
  assign do_read  = access_last && !req_we_q;
  assign do_load  = (state_q == S_IDLE) && !bus.dm_en && bus.load_en &&
                    load_in_range && !rst;

  assign bus.dm_out = dout_q;
  assign bus.status = status_q;

  // State register.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode plus the capture / access strobes and status code.
  always_comb begin
    state_d     = state_q;
    capture     = 1'b0;
    access_last = 1'b0;
    status_d    = ST_IDLE;
    case (state_q)
      S_IDLE: begin
        if (bus.dm_en) begin
          capture = 1'b1;
          state_d = req_in_range ? S_BUSY : S_ERR;
        end
      end
      S_BUSY: begin
        if (count_q == WAIT_L) begin
          access_last = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE, S_ERR: begin
        if (!bus.dm_en) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Status is registered from the next state so it tracks the state
    // change on the same edge rather than one cycle behind.
    case (state_d)
      S_IDLE:  status_d = ST_IDLE;
      S_BUSY:  status_d = ST_BUSY;
      S_DONE:  status_d = ST_DONE;
      S_ERR:   status_d = ST_ERR;
      default: status_d = ST_IDLE;
    endcase
  end

  // Status register.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      status_q <= ST_IDLE;
    end else begin
      status_q <= status_d;
    end
  end

  // Request latches; only the RAM index bits are kept since out-of-range
  // requests never reach BUSY.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      req_we_q    <= 1'b0;
      req_idx_q   <= '0;
      req_wdata_q <= '0;
    end else if (capture) begin
      req_we_q    <= bus.dm_we;
      req_idx_q   <= bus.addr[IDX_W-1:0];
      req_wdata_q <= bus.wdata;
    end
  end

  // Wait-state counter: cleared on capture, advanced each BUSY cycle.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (capture) begin
      count_q <= '0;
    end else if (state_q == S_BUSY && !access_last) begin
      count_q <= count_q + 4'd1;
    end
  end

  // RAM array; contents deliberately survive reset.
  always_ff @(posedge clock) begin
    if (do_write) begin
      mem[req_idx_q] <= req_wdata_q;
    end else if (do_load) begin
      mem[bus.load_addr[IDX_W-1:0]] <= bus.load_data;
    end
  end

  // Read data register: changes only on a completed read or on reset.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      dout_q <= '0;
    end else if (do_read) begin
      dout_q <= mem[req_idx_q];
    end
  end

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: a transaction-level model predicts
// status and dm_out every cycle, and literal expectations pin key points.
module tb_dm_responder;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 16;
  localparam int DEPTH  = 1024;
  localparam int WAITC  = 2;

  logic clock;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  dm_responder_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  dm_responder #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .WAIT_CYCLES(WAITC)
  ) dut (
    .clock(clock),
    .rst  (rst),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  logic [1:0]  m_status = 2'b00;
  logic [7:0]  m_dout   = 8'h00;
  logic [7:0]  m_mem [DEPTH];
  logic        m_we;
  int          m_addr;
  logic [7:0]  m_wdata;
  int          m_due;
  int          cyc = 0;

  always @(posedge clock or posedge rst) begin
    if (rst) begin
      m_status = 2'b00;
      m_dout   = 8'h00;
    end else begin
      cyc++;
      case (m_status)
        2'b00: begin
          if (bus.dm_en) begin
            if (int'(bus.addr) >= DEPTH) m_status = 2'b11;
            else begin
              m_status = 2'b01;
              m_we     = bus.dm_we;
              m_addr   = int'(bus.addr);
              m_wdata  = bus.wdata;
              m_due    = cyc + WAITC + 1;
            end
          end else if (bus.load_en && int'(bus.load_addr) < DEPTH) begin
            m_mem[int'(bus.load_addr)] = bus.load_data;
          end
        end
        2'b01: begin
          if (cyc == m_due) begin
            if (m_we) m_mem[m_addr] = m_wdata;
            else      m_dout = m_mem[m_addr];
            m_status = 2'b10;
          end
        end
        default: if (!bus.dm_en) m_status = 2'b00;
      endcase
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    check("status_vs_model", {30'd0, bus.status}, {30'd0, m_status});
    check("dout_vs_model",   {24'd0, bus.dm_out}, {24'd0, m_dout});
  end

  // ---------------- stimulus helpers ----------------
  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    bus.load_en   = 1'b1;
    bus.load_addr = a;
    bus.load_data = d;
    @(negedge clock);
    bus.load_en = 1'b0;
  endtask

  task automatic req(input logic we, input logic [15:0] a, input logic [7:0] d,
                     input bit mid_chg, input bit drop, input int hold,
                     output logic [7:0] rd, output int busy_n, output logic [1:0] fin);
    bit ok;
    bus.dm_en = 1'b1;
    bus.dm_we = we;
    bus.addr  = a;
    bus.wdata = d;
    busy_n = 0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (bus.status == 2'b01) begin
        busy_n++;
        if (mid_chg) begin
          bus.addr  = 16'h0020;
          bus.wdata = 8'hFF;
        end
        if (drop) bus.dm_en = 1'b0;
      end else begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL req_timeout: status stuck at %0h want done/error", bus.status);
    end
    fin = bus.status;
    rd  = bus.dm_out;
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      check("hold_status", {30'd0, bus.status}, 32'h2);
    end
    bus.dm_en = 1'b0;
    @(negedge clock);
    check("release_idle", {30'd0, bus.status}, 32'h0);
  endtask

  logic [7:0] rd;
  int         bn;
  logic [1:0] fin;

  initial begin
    #200000;
    $display("FAIL watchdog: no finish by %0t want earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    bus.dm_en = 1'b0; bus.dm_we = 1'b0; bus.addr = '0; bus.wdata = '0;
    bus.load_en = 1'b0; bus.load_addr = '0; bus.load_data = '0;
    #1 rst = 1'b1;
    @(negedge clock);
    @(negedge clock);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("post_reset_idle", {30'd0, bus.status}, 32'h0);
    end
    check("post_reset_dout", {24'd0, bus.dm_out}, 32'h0);

    preload(16'h0000, 8'hC3);
    preload(16'h0005, 8'h00);
    preload(16'h0010, 8'h00);
    preload(16'h0020, 8'h11);

    // Write with addr/wdata disturbed during BUSY: latched values must land.
    req(1'b1, 16'h0010, 8'h5A, 1'b1, 1'b0, 0, rd, bn, fin);
    check("wr_busy_cycles", bn, 3);
    check("wr_fin", {30'd0, fin}, 32'h2);
    check("wr_dout_unchanged", {24'd0, rd}, 32'h0);

    req(1'b0, 16'h0020, 8'h00, 1'b0, 1'b0, 0, rd, bn, fin);
    check("rd20_untouched", {24'd0, rd}, 32'h11);
    req(1'b0, 16'h0010, 8'h00, 1'b0, 1'b0, 0, rd, bn, fin);
    check("rd10_value", {24'd0, rd}, 32'h5A);
    check("rd10_busy_cycles", bn, 3);

    // Out-of-range read: immediate error, dm_out untouched.
    req(1'b0, 16'h0400, 8'h00, 1'b0, 1'b0, 0, rd, bn, fin);
    check("err_fin", {30'd0, fin}, 32'h3);
    check("err_busy_cycles", bn, 0);
    check("err_dout_kept", {24'd0, rd}, 32'h5A);
    req(1'b1, 16'h0400, 8'h99, 1'b0, 1'b0, 0, rd, bn, fin);
    check("err_wr_fin", {30'd0, fin}, 32'h3);
    req(1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 0, rd, bn, fin);
    check("rd0_no_alias", {24'd0, rd}, 32'hC3);

    // dm_en held 5 cycles past done: status stays 10, no second access.
    req(1'b0, 16'h0010, 8'h00, 1'b0, 1'b0, 5, rd, bn, fin);
    check("hold_rd_value", {24'd0, rd}, 32'h5A);

    // dm_en dropped during BUSY: access completes, one DONE cycle.
    req(1'b1, 16'h0020, 8'h22, 1'b0, 1'b1, 0, rd, bn, fin);
    check("drop_fin", {30'd0, fin}, 32'h2);
    check("drop_busy_cycles", bn, 3);
    req(1'b0, 16'h0020, 8'h00, 1'b0, 1'b0, 0, rd, bn, fin);
    check("drop_wr_landed", {24'd0, rd}, 32'h22);

    // Preload collides with a request: request wins, preload dropped.
    bus.load_en = 1'b1; bus.load_addr = 16'h0005; bus.load_data = 8'h33;
    req(1'b0, 16'h0005, 8'h00, 1'b0, 1'b0, 0, rd, bn, fin);
    bus.load_en = 1'b0;
    check("prio_rd", {24'd0, rd}, 32'h00);
    req(1'b0, 16'h0005, 8'h00, 1'b0, 1'b0, 0, rd, bn, fin);
    check("prio_mem_kept", {24'd0, rd}, 32'h00);
    preload(16'h0005, 8'h33);
    req(1'b0, 16'h0005, 8'h00, 1'b0, 1'b0, 0, rd, bn, fin);
    check("preload_rd", {24'd0, rd}, 32'h33);

    // Out-of-range preload is dropped, must not alias onto address 0.
    preload(16'h0400, 8'hEE);
    req(1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 0, rd, bn, fin);
    check("oob_preload_dropped", {24'd0, rd}, 32'hC3);

    // Reset mid-write: immediate idle, dm_out cleared, write abandoned.
    bus.dm_en = 1'b1; bus.dm_we = 1'b1; bus.addr = 16'h0020; bus.wdata = 8'h77;
    @(negedge clock);
    check("pre_reset_busy", {30'd0, bus.status}, 32'h1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_status", {30'd0, bus.status}, 32'h0);
    check("async_rst_dout", {24'd0, bus.dm_out}, 32'h0);
    bus.dm_en = 1'b0;
    @(negedge clock);
    @(negedge clock);
    rst = 1'b0;
    @(negedge clock);
    check("after_rst_idle", {30'd0, bus.status}, 32'h0);
    req(1'b0, 16'h0020, 8'h00, 1'b0, 1'b0, 0, rd, bn, fin);
    check("rst_write_abandoned", {24'd0, rd}, 32'h22);

    repeat (2) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
